// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the fetch/data memory port arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Port ids double as bit positions in the {data, fetch} request vectors.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
//------------------------------------------------------------------------------
// Module   : arb_pick
// Brief    : Combinational 2-way grant selector; round-robin under MEM_ARB_RR_EN,
//            fixed data-over-fetch priority otherwise.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic [1:0] i_excl,
`ifdef MEM_ARB_RR_EN
  input  logic       i_last,
`endif
  output logic       o_gnt,
  output logic       o_valid
);

  logic [1:0] w_live;

  assign w_live  = i_req & ~i_excl;
  assign o_valid = |w_live;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    if (&w_live) begin
      o_gnt = ~i_last;
    end else begin
      o_gnt = w_live[PORT_D];
    end
  end
`else
  assign o_gnt = w_live[PORT_D];
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_port_arbiter
// Brief    : Shares one mack-handshaked memory between fetch and data ports.
//            MEM_ARB_RR_EN selects round-robin arbitration on contention.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] irdata,
  output logic          iready,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dready,
  output logic          mreq,
  output logic          mwe,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  input  logic          mack,
  input  logic [DW-1:0] mrdata,
  output logic          busy
);

  state_t r_state;
  logic   w_gnt;
  logic   w_valid;
`ifdef MEM_ARB_RR_EN
  logic   r_last;
`endif

  // The port pulsing ready this cycle sits out arbitration.
  arb_pick u_pick (
    .i_req   ({dreq, ireq}),
    .i_excl  ({dready, iready}),
`ifdef MEM_ARB_RR_EN
    .i_last  (r_last),
`endif
    .o_gnt   (w_gnt),
    .o_valid (w_valid)
  );

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      mreq    <= 1'b0;
      mwe     <= 1'b0;
      maddr   <= '0;
      mwdata  <= '0;
      irdata  <= '0;
      drdata  <= '0;
      iready  <= 1'b0;
      dready  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last  <= PORT_I;
`endif
    end else begin
      iready <= 1'b0;
      dready <= 1'b0;
      case (r_state)
        IDLE, RESP: begin
          if (w_valid) begin
            mreq <= 1'b1;
`ifdef MEM_ARB_RR_EN
            r_last <= w_gnt;
`endif
            if (w_gnt == PORT_D) begin
              mwe     <= dwe;
              maddr   <= daddr;
              mwdata  <= dwdata;
              r_state <= BUSY_D;
            end else begin
              mwe     <= 1'b0;
              maddr   <= iaddr;
              mwdata  <= '0;
              r_state <= BUSY_I;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY_I: begin
          if (mack) begin
            irdata  <= mrdata;
            iready  <= 1'b1;
            mreq    <= 1'b0;
            r_state <= RESP;
          end
        end
        BUSY_D: begin
          if (mack) begin
            // Stores leave the load-data register untouched.
            if (!mwe) begin
              drdata <= mrdata;
            end
            dready  <= 1'b1;
            mreq    <= 1'b0;
            mwe     <= 1'b0;
            r_state <= RESP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter (honours MEM_ARB_RR_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0, mack = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dwdata = '0, mrdata = '0;
  logic [31:0] irdata, drdata, maddr, mwdata;
  logic        iready, dready, mreq, mwe, busy;

  int ncmp = 0;
  int nfail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .iready(iready),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .drdata(drdata), .dready(dready),
    .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata),
    .mack(mack), .mrdata(mrdata), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: one outstanding access at most; a port that
  // is being answered this cycle cannot win the next grant.
  int          m_owner = 0;  // 0 none, 1 fetch, 2 data
  logic        m_mreq = 0, m_mwe = 0, m_irdy = 0, m_drdy = 0;
  logic [31:0] m_maddr = 0, m_mwdata = 0, m_ird = 0, m_drd = 0;
  bit          m_pi, m_pd;
  int          m_win;
`ifdef MEM_ARB_RR_EN
  int          m_last = 0;   // 0 fetch, 1 data
`endif

  always @(posedge clk) begin
    if (reset) begin
      m_owner = 0; m_mreq = 0; m_mwe = 0; m_irdy = 0; m_drdy = 0;
      m_maddr = 0; m_mwdata = 0; m_ird = 0; m_drd = 0;
`ifdef MEM_ARB_RR_EN
      m_last = 0;
`endif
    end else if (m_owner != 0) begin
      m_irdy = 0; m_drdy = 0;
      if (mack) begin
        if (m_owner == 1) begin
          m_ird = mrdata; m_irdy = 1;
        end else begin
          if (!m_mwe) m_drd = mrdata;
          m_drdy = 1;
        end
        m_owner = 0; m_mreq = 0; m_mwe = 0;
      end
    end else begin
      m_pi = ireq && !m_irdy;
      m_pd = dreq && !m_drdy;
      m_irdy = 0; m_drdy = 0;
      m_win = 0;
      if (m_pi && m_pd) begin
`ifdef MEM_ARB_RR_EN
        m_win = (m_last == 1) ? 1 : 2;
`else
        m_win = 2;
`endif
      end else if (m_pd) m_win = 2;
      else if (m_pi) m_win = 1;
      if (m_win != 0) begin
        m_owner = m_win; m_mreq = 1;
`ifdef MEM_ARB_RR_EN
        m_last = (m_win == 2) ? 1 : 0;
`endif
        if (m_win == 2) begin
          m_mwe = dwe; m_maddr = daddr; m_mwdata = dwdata;
        end else begin
          m_mwe = 0; m_maddr = iaddr;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sb_mreq",   32'(mreq),   32'(m_mreq));
      chk("sb_iready", 32'(iready), 32'(m_irdy));
      chk("sb_dready", 32'(dready), 32'(m_drdy));
      chk("sb_irdata", irdata, m_ird);
      chk("sb_drdata", drdata, m_drd);
      chk("sb_busy",   32'(busy),   32'((m_owner != 0) || m_irdy || m_drdy));
      if (m_mreq) begin
        chk("sb_maddr", maddr, m_maddr);
        chk("sb_mwe",   32'(mwe), 32'(m_mwe));
        if (m_mwe) chk("sb_mwdata", mwdata, m_mwdata);
      end
    end
  end

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_ird;
    logic [31:0] exp_drd;
  } vec_t;

  task automatic run_vec(input vec_t v);
    if (v.is_d) begin
      dreq = 1; dwe = v.we; daddr = v.addr; dwdata = v.wdata;
    end else begin
      ireq = 1; iaddr = v.addr;
    end
    step();
    for (int k = 0; k <= v.waits; k++) begin
      chk("vec_mreq", 32'(mreq), 32'd1);
      chk("vec_maddr", maddr, v.addr);
      chk("vec_mwe", 32'(mwe), 32'(v.is_d && v.we));
      if (v.is_d) chk("vec_mwdata", mwdata, v.wdata);
      if (k == v.waits) begin
        mack = 1; mrdata = v.rdata;
      end
      step();
    end
    chk("vec_iready", 32'(iready), 32'(!v.is_d));
    chk("vec_dready", 32'(dready), 32'(v.is_d));
    chk("vec_irdata", irdata, v.exp_ird);
    chk("vec_drdata", drdata, v.exp_drd);
    ireq = 0; dreq = 0; dwe = 0; mack = 0; mrdata = 32'h0BAD0BAD;
    step();
    chk("vec_ready_done", 32'({iready, dready}), 32'd0);
    chk("vec_busy_done", 32'(busy), 32'd0);
    chk("vec_irdata_hold", irdata, v.exp_ird);
    chk("vec_drdata_hold", drdata, v.exp_drd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[5];
    logic [31:0] g[$];
    logic [31:0] g_exp[4];
    int          bound;

    vt[0] = '{1'b0, 1'b0, 32'h10,       32'h0,        32'h00500113, 0, 32'h00500113, 32'h0};
    vt[1] = '{1'b1, 1'b1, 32'h64,       32'hDEADBEEF, 32'h12345678, 3, 32'h00500113, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h20,       32'h0,        32'hCAFEF00D, 1, 32'h00500113, 32'hCAFEF00D};
    vt[3] = '{1'b1, 1'b1, 32'h30,       32'h1,        32'h77777777, 0, 32'h00500113, 32'hCAFEF00D};
    vt[4] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        32'hA5A5A5A5, 2, 32'hA5A5A5A5, 32'hCAFEF00D};
    g_exp = '{32'h100, 32'h200, 32'h100, 32'h200};

    step(); step();
    chk("rst_mreq", 32'(mreq), 32'd0);
    chk("rst_mwe", 32'(mwe), 32'd0);
    chk("rst_maddr", maddr, 32'd0);
    chk("rst_mwdata", mwdata, 32'd0);
    chk("rst_rdata", irdata | drdata, 32'd0);
    chk("rst_ready", 32'({iready, dready}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 0;
    chk_en = 1;

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // Simultaneous load and fetch: data first, fetch granted straight from RESP.
    dreq = 1; dwe = 0; daddr = 32'h20; ireq = 1; iaddr = 32'h04;
    step();
    chk("sim_first_addr", maddr, 32'h20);
    mack = 1; mrdata = 32'd7;
    step();
    chk("sim_dready", 32'(dready), 32'd1);
    chk("sim_iready_wait", 32'(iready), 32'd0);
    chk("sim_drdata", drdata, 32'd7);
    dreq = 0; mack = 0;
    step();
    chk("sim_second_mreq", 32'(mreq), 32'd1);
    chk("sim_second_addr", maddr, 32'h04);
    mack = 1; mrdata = 32'h13;
    step();
    chk("sim_iready", 32'(iready), 32'd1);
    chk("sim_irdata", irdata, 32'h13);
    ireq = 0; mack = 0;
    step();

    // Both ports held high: grants must alternate D, I, D, I.
    dreq = 1; dwe = 0; daddr = 32'h100; ireq = 1; iaddr = 32'h200;
    mack = 1; mrdata = 32'h55;
    bound = 0;
    while (g.size() < 4 && bound < 20) begin
      step();
      bound++;
      if (mreq) g.push_back(maddr);
    end
    chk("alt_grant_count", 32'(g.size()), 32'd4);
    for (int k = 0; k < 4 && k < g.size(); k++) chk("alt_grant_addr", g[k], g_exp[k]);
    step();
    dreq = 0; ireq = 0; mack = 0;
    step();
    chk("alt_idle_busy", 32'(busy), 32'd0);

    // Reset while waiting for mack on a load.
    dreq = 1; dwe = 0; daddr = 32'h40;
    step(); step();
    chk("rstmid_mreq_before", 32'(mreq), 32'd1);
    reset = 1;
    step();
    reset = 0; dreq = 0;
    chk("rstmid_mreq", 32'(mreq), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_dready", 32'(dready), 32'd0);
    chk("rstmid_drdata", drdata, 32'd0);
    chk("rstmid_irdata", irdata, 32'd0);
    mack = 1; mrdata = 32'hFEEDFACE;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("spur_ready", 32'({iready, dready}), 32'd0);
      chk("spur_busy", 32'(busy), 32'd0);
      chk("spur_drdata", drdata, 32'd0);
    end
    mack = 0;

    // Randomized traffic against the scoreboard; requesters hold until ready.
    for (int c = 0; c < 4000; c++) begin
      step();
      if (!ireq) begin
        if ($urandom_range(3) == 0) begin ireq = 1; iaddr = $urandom; end
      end else if (m_irdy) begin
        if ($urandom_range(1) == 0) ireq = 0; else iaddr = $urandom;
      end
      if (!dreq) begin
        if ($urandom_range(3) == 0) begin
          dreq = 1; dwe = 1'($urandom_range(1)); daddr = $urandom; dwdata = $urandom;
        end
      end else if (m_drdy) begin
        if ($urandom_range(1) == 0) dreq = 0;
        else begin dwe = 1'($urandom_range(1)); daddr = $urandom; dwdata = $urandom; end
      end
      mack = ($urandom_range(2) == 0);
      mrdata = $urandom;
    end

    step();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the pipeline's instruction-fetch port and data (load/store) port. Requests are accepted and the winner is registered onto a mack-handshaked memory bus. Completion is returned to the winning port as a one-cycle ready pulse with registered read data. The pipeline's hazard logic stalls on (req && !ready) for each port. Sits between the datapath and the memory models in the top level, replacing separate instruction and data memories.

Parameters:
AW, 32, address width of all ports
DW, 32, data width of all ports

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
ireq  in  1  fetch request, level; held until iready
iaddr  in  AW  fetch address
irdata  out  DW  fetched instruction, valid in iready cycle, held after
iready  out  1  one-cycle fetch completion pulse
dreq  in  1  data request, level; held until dready
dwe  in  1  1 = store, 0 = load
daddr  in  AW  data address
dwdata  in  DW  store data
drdata  out  DW  load data, valid in dready cycle, held after
dready  out  1  one-cycle data completion pulse
mreq  out  1  memory request, registered
mwe  out  1  memory write enable, registered
maddr  out  AW  memory address, registered
mwdata  out  DW  memory write data, registered
mack  in  1  memory completion; mrdata valid in same cycle for reads
mrdata  in  DW  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state = IDLE; last-grant = I.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- Arbitration point is IDLE, or RESP with a non-completing port pending.
  - Default: dreq beats ireq (fixed priority).
  - The port pulsing ready in the current cycle is excluded from arbitration.
- IDLE + winner: at the next edge, latch winner attributes into mreq/mwe/maddr/mwdata and enter BUSY_x.
  - mwe = dwe for the data port; mwe = 0 for fetch.
- BUSY_x: hold mreq and attributes stable until mack is sampled high.
  - On mack: capture mrdata into xrdata (reads only; drdata unchanged on stores).
  - Drop mreq and pulse xready in the following cycle (state RESP).
- RESP: xready = 1 for exactly one cycle.
  - Same edge: if the other port requests, grant it directly into BUSY_y; else go to IDLE.
- Latency with zero-wait memory (mack in first mreq cycle):
  - req seen in cycle 0, mreq in cycle 1, ready in cycle 2.
  - Back-to-back alternating ports: one transaction per 2 cycles.
  - Same port repeating: one transaction per 3 cycles.
- mack while not in BUSY_x: ignored, no state change.
- Requester dropping req before ready: undefined usage. The transaction still completes and ready still pulses.
- Simultaneous ireq and dreq in IDLE: data granted, fetch waits (ireq stays high, iready stays low).
- Reset mid-transaction: mreq drops in the cycle after the reset edge. The in-flight access is abandoned. No ready pulse is emitted. rdata registers clear to 0.
- Arithmetic: none. Addresses are passed through unmodified; no alignment checks.

Optional Feature:
MEM_ARB_RR_EN
- Defined: when both ports contend at an arbitration point, grant the port not granted last. The last-grant register updates on every grant.
- Undefined: fixed data-over-fetch priority. The last-grant register is omitted.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, BUSY_I, BUSY_D, RESP)
  - port-id constants PORT_I = 0, PORT_D = 1
  - default AW/DW constants
- Sub-module arb_pick: combinational 2-way selector (requests, exclude mask, last-grant → grant id, valid). Holds the MEM_ARB_RR_EN variation.
- Everything else stays in the top FSM.

Test Plan:
- ireq=1, iaddr=0x10, mack in first mreq cycle, mrdata=0x00500113 → maddr=0x10, mwe=0, iready pulses in cycle 2, irdata=0x00500113.
- dreq=1, dwe=1, daddr=0x64, dwdata=0xDEADBEEF, mack after 3 wait cycles → mwe=1, mwdata=0xDEADBEEF stable for 4 cycles, dready one pulse, drdata unchanged.
- ireq and dreq both high in the same cycle (load 0x20 → mrdata 7; fetch 0x04 → mrdata 0x13), RR disabled → data served first (drdata=7), then fetch via RESP→BUSY_I with no IDLE cycle (irdata=0x13).
- MEM_ARB_RR_EN defined, both held high for 4 transactions → grants alternate D, I, D, I.
- Reset asserted while in BUSY_D awaiting mack → next cycle mreq=0, busy=0, no dready pulse, drdata=0. A later mack is ignored.
- mack pulsed while in IDLE with no requests → no ready pulses, state stays IDLE, busy=0.
